// File: rtl/eth_phy_pkg.sv
// Shared definitions for the 10G PHY receive-side link controller.
package eth_phy_pkg;

   localparam int LINK_STATE_W = 3;

   typedef enum logic [LINK_STATE_W-1:0] {
      LINK_IDLE         = 3'd0,
      LINK_RESET_SERDES = 3'd1,
      LINK_WAIT_LOCK    = 3'd2,
      LINK_WAIT_UP      = 3'd3,
      LINK_UP           = 3'd4
   } link_state_e;

endpackage

// File: rtl/eth_sat_counter.sv
// Saturating accumulator: adds an unsigned increment each cycle, sticks at all-ones,
// and clears to zero with priority over the increment.
module eth_sat_counter #(
   parameter int WIDTH = 32,
   parameter int INC_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [INC_W-1:0] inc,
   output logic [WIDTH-1:0] count
);

   localparam int SW = ((WIDTH > INC_W) ? WIDTH : INC_W) + 1;

   // Widened add so any carry out of WIDTH bits is visible and forces saturation.
   function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                input logic [INC_W-1:0] b);
      logic [SW-1:0] s;
      s = SW'(a) + SW'(b);
      if (|s[SW-1:WIDTH])
         return '1;
      else
         return s[WIDTH-1:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else
         count <= sat_add(count, inc);
   end

endmodule

// File: rtl/eth_phy_10g_link_ctrl.sv
// Link bring-up/supervision FSM for the 10G PHY RX side, plus saturating
// error statistics fed by the PHY status strobes.
module eth_phy_10g_link_ctrl
   import eth_phy_pkg::*;
#(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 1024,
   parameter int UP_DEBOUNCE  = 64,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                    rx_clk,
   input  logic                    rx_rst,
   input  logic                    cfg_link_enable,
   input  logic                    stats_clear,
   input  logic                    rx_block_lock,
   input  logic                    rx_high_ber,
   input  logic                    rx_status,
   input  logic                    rx_bad_block,
   input  logic                    rx_sequence_error,
   input  logic [6:0]              rx_error_count,
   input  logic                    serdes_rx_reset_req,
   output logic                    serdes_rx_reset,
   output logic                    link_up,
   output logic [LINK_STATE_W-1:0] link_state,
   output logic [7:0]              retry_count,
   output logic [CNT_WIDTH-1:0]    link_down_count,
   output logic [CNT_WIDTH-1:0]    bad_block_count,
   output logic [CNT_WIDTH-1:0]    seq_error_count,
   output logic [CNT_WIDTH-1:0]    error_sum
);

   localparam int TMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int TMAX   = (TMAX_A > UP_DEBOUNCE) ? TMAX_A : UP_DEBOUNCE;
   localparam int TW     = $clog2(TMAX + 1);

   localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] DEB_LAST  = TW'(UP_DEBOUNCE - 1);

   link_state_e   state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          healthy;
   logic          serdes_rx_reset_d;
   logic          link_up_d;
   logic          retry_inc;
   logic          retry_clr;
   logic          link_down_ev;
   logic          req_active;

   assign healthy    = rx_block_lock & rx_status & ~rx_high_ber;
   assign req_active = serdes_rx_reset_req &
                       ((state_q == LINK_WAIT_LOCK) || (state_q == LINK_WAIT_UP) ||
                        (state_q == LINK_UP));
   assign link_state = state_q;

   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         state_q         <= LINK_IDLE;
         cnt_q           <= '0;
         serdes_rx_reset <= 1'b1;
         link_up         <= 1'b0;
         retry_count     <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         serdes_rx_reset <= serdes_rx_reset_d;
         link_up         <= link_up_d;
         if (retry_clr)
            retry_count <= '0;
         else if (retry_inc && (retry_count != 8'hFF))
            retry_count <= retry_count + 8'd1;
      end
   end

   // cnt is the reset timer, lock timer or debounce count depending on state;
   // it restarts from zero on every state entry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!cfg_link_enable) begin
         state_d = LINK_IDLE;
         cnt_d   = '0;
      end else if (req_active) begin
         state_d = LINK_RESET_SERDES;
         cnt_d   = '0;
      end else begin
         case (state_q)
            LINK_IDLE: begin
               state_d = LINK_RESET_SERDES;
               cnt_d   = '0;
            end
            LINK_RESET_SERDES: begin
               if (cnt_q == RST_LAST) begin
                  state_d = LINK_WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            LINK_WAIT_LOCK: begin
               if (rx_block_lock) begin
                  state_d = LINK_WAIT_UP;
                  cnt_d   = '0;
               end else if (cnt_q == LOCK_LAST) begin
                  state_d = LINK_RESET_SERDES;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            LINK_WAIT_UP: begin
               if (!rx_block_lock) begin
                  state_d = LINK_WAIT_LOCK;
                  cnt_d   = '0;
               end else if (!healthy) begin
                  cnt_d = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d = LINK_UP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            LINK_UP: begin
               if (!healthy) begin
                  state_d = LINK_WAIT_LOCK;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = LINK_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they align with link_state.
   always_comb begin
      serdes_rx_reset_d = (state_d == LINK_IDLE) || (state_d == LINK_RESET_SERDES);
      link_up_d         = (state_d == LINK_UP);
      retry_inc         = (state_q == LINK_RESET_SERDES) && (state_d == LINK_WAIT_LOCK);
      retry_clr         = (state_q == LINK_WAIT_UP) && (state_d == LINK_UP);
      link_down_ev      = cfg_link_enable && (state_q == LINK_UP) && (state_d != LINK_UP);
   end

   eth_sat_counter #(.WIDTH(CNT_WIDTH), .INC_W(1)) u_link_down_cnt (
      .clk   (rx_clk),
      .rst   (rx_rst),
      .clr   (stats_clear),
      .inc   (link_down_ev),
      .count (link_down_count)
   );

   eth_sat_counter #(.WIDTH(CNT_WIDTH), .INC_W(1)) u_bad_block_cnt (
      .clk   (rx_clk),
      .rst   (rx_rst),
      .clr   (stats_clear),
      .inc   (rx_bad_block),
      .count (bad_block_count)
   );

   eth_sat_counter #(.WIDTH(CNT_WIDTH), .INC_W(1)) u_seq_error_cnt (
      .clk   (rx_clk),
      .rst   (rx_rst),
      .clr   (stats_clear),
      .inc   (rx_sequence_error),
      .count (seq_error_count)
   );

   eth_sat_counter #(.WIDTH(CNT_WIDTH), .INC_W(7)) u_error_sum (
      .clk   (rx_clk),
      .rst   (rx_rst),
      .clr   (stats_clear),
      .inc   (rx_error_count),
      .count (error_sum)
   );

endmodule

// File: doc/eth_phy_10g_link_ctrl.md
Name: eth_phy_10g_link_ctrl

Overview:
Link bring-up and supervision controller for the 10G PHY receive side; lives in the rx_clk domain beside eth_phy_10g.
- Sequences the SerDes RX reset and waits for block lock, then debounces link-up.
- Tears the link down on lock loss, high BER or rx_status loss.
- Accumulates saturating error statistics from PHY status strobes for software.

Parameters:
RST_CYCLES, 16, cycles serdes_rx_reset is held high per reset attempt (>=1)
LOCK_TIMEOUT, 1024, cycles in WAIT_LOCK before retrying SerDes reset (>=2)
UP_DEBOUNCE, 64, consecutive healthy cycles required before link_up (>=1)
CNT_WIDTH, 32, width of statistics counters

Ports:
rx_clk  in  1  sole clock (PHY RX clock)
rx_rst  in  1  asynchronous, active-high reset
cfg_link_enable  in  1  0 forces IDLE
stats_clear  in  1  single-cycle pulse; zeroes all statistics counters
rx_block_lock  in  1  PHY block lock
rx_high_ber  in  1  PHY high-BER flag
rx_status  in  1  PHY link status
rx_bad_block  in  1  per-cycle bad-block strobe
rx_sequence_error  in  1  per-cycle sequence-error strobe
rx_error_count  in  7  errors reported this cycle (added as-is)
serdes_rx_reset_req  in  1  PHY request for SerDes reset
serdes_rx_reset  out  1  SerDes RX reset drive
link_up  out  1  link healthy and debounced
link_state  out  3  encoded FSM state
retry_count  out  8  SerDes reset attempts since last LINK_UP; saturating
link_down_count  out  CNT_WIDTH  LINK_UP exits; saturating
bad_block_count  out  CNT_WIDTH  count of rx_bad_block cycles; saturating
seq_error_count  out  CNT_WIDTH  count of rx_sequence_error cycles; saturating
error_sum  out  CNT_WIDTH  running sum of rx_error_count; saturating

Behaviour:
Reset values (rx_rst high): state=IDLE, serdes_rx_reset=1, link_up=0, all counters=0.
State encodings: IDLE=0, RESET_SERDES=1, WAIT_LOCK=2, WAIT_UP=3, LINK_UP=4.
- IDLE: serdes_rx_reset=1. cfg_link_enable=1 -> RESET_SERDES, timer cleared.
- RESET_SERDES:
  - serdes_rx_reset=1 for exactly RST_CYCLES cycles.
  - Then -> WAIT_LOCK; retry_count+1 on that transition.
- WAIT_LOCK: serdes_rx_reset=0; timer counts.
  - rx_block_lock=1 -> WAIT_UP, debounce cleared.
  - Timer reaches LOCK_TIMEOUT-1 without lock -> RESET_SERDES.
- WAIT_UP: healthy = rx_block_lock & rx_status & ~rx_high_ber.
  - Healthy: debounce+1. Any unhealthy cycle clears debounce.
  - rx_block_lock=0 -> WAIT_LOCK, timer cleared.
  - After UP_DEBOUNCE consecutive healthy cycles -> LINK_UP; retry_count cleared.
- LINK_UP: link_up=1 (registered, asserted the cycle the state is LINK_UP).
  - Any unhealthy cycle -> WAIT_LOCK; link_up=0 next cycle; link_down_count+1.
- serdes_rx_reset_req=1 in WAIT_LOCK, WAIT_UP or LINK_UP:
  - -> RESET_SERDES.
  - Counts as a LINK_UP exit if it occurs in LINK_UP.
  - Priority: the request wins over all other transitions.
- cfg_link_enable=0 in any state -> IDLE next cycle. Highest priority; no statistics change.
- serdes_rx_reset is driven from a register (no glitch).
- Statistics update every cycle regardless of state, including IDLE.
- Saturation:
  - All counters stick at their maximum value.
  - error_sum saturates to all-ones when the add would overflow. The add is zero-extended; the carry is detected.
- stats_clear: highest priority over increment. Counters become 0 that cycle; that cycle's increments are dropped. retry_count is not affected.
- Reset mid-operation: async return to reset values; no partial reset pulse is remembered.

Decomposition:
- Shared package eth_phy_pkg:
  - link-state enum constants (LINK_IDLE, LINK_RESET_SERDES, LINK_WAIT_LOCK, LINK_WAIT_UP, LINK_UP).
  - the 3-bit state width.
- One sub-module: eth_sat_counter (parameter WIDTH; inputs clk, rst, clr, inc value; output count; saturating add). Instantiated four times.

Test Plan:
1. Reset, cfg_link_enable=1, rx_block_lock tied 1, rx_status=1, rx_high_ber=0 -> serdes_rx_reset high 16 cycles; link_up=1 exactly 64 healthy cycles after WAIT_UP entry; retry_count=0.
2. rx_block_lock held 0 -> serdes_rx_reset re-pulses every 16+1024 cycles; retry_count increments 1,2,3; link_up stays 0.
3. In LINK_UP, pulse rx_high_ber one cycle -> link_up drops next cycle; state=2; link_down_count=1; re-up after 64 healthy cycles.
4. serdes_rx_reset_req in LINK_UP the same cycle as rx_block_lock=0 -> state=1 (request wins); link_down_count +1 only once.
5. CNT_WIDTH=8: rx_error_count=7'd100 for 3 cycles -> error_sum=100,200,255 (saturated); stats_clear concurrent with rx_bad_block=1 -> bad_block_count=0.
6. Deassert cfg_link_enable during WAIT_UP -> IDLE next cycle, serdes_rx_reset=1; async rx_rst mid RESET_SERDES -> all counters 0, state 0.
